uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one UART TX serializer (start/data/done interface, 1-cycle done pulse) between N_REQ requesters.
//  Round-robin arbitration with valid/ready handshakes; latches the winning byte and pulses tx_start.
//  Waits for tx_done, with a watchdog timeout, then enforces an optional idle gap between frames.
//  Sits between the host-side byte sources and the serializer.
// PARAMETERS
//  DATA_WIDTH     8   byte width; matches serializer data_width
//  N_REQ          4   number of requesters (>=2)
//  TIMEOUT_CYCLES 64  max cycles in WAIT_DONE before abort (>= DATA_WIDTH+4)
//  GAP_CYCLES     2   idle cycles after each frame before next grant (0 allowed)
// PORTS
//  clk         in   1                 rising-edge clock
//  Rst_n       in   1                 asynchronous, active-low reset
//  req_valid   in   N_REQ             per-requester byte available
//  req_ready   out  N_REQ             per-requester accept, one-hot or zero, combinational
//  req_data    in   N_REQ*DATA_WIDTH  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//  tx_start    out  1                 1-cycle start pulse to serializer
//  tx_data     out  DATA_WIDTH        latched byte; stable from LAUNCH to end of WAIT_DONE
//  tx_done     in   1                 serializer frame-complete pulse
//  grant_id    out  clog2(N_REQ)      index of requester currently being served
//  busy        out  1                 1 in any state except IDLE
//  frame_done  out  1                 1-cycle pulse: frame completed normally
//  timeout_err out  1                 1-cycle pulse: frame aborted by watchdog
// BEHAVIOUR
//  Reset (async, Rst_n=0): state=IDLE; tx_start=0, tx_data=0, grant_id=0, frame_done=0, timeout_err=0, timers=0.
//   rr pointer=N_REQ-1, so requester 0 has first priority. busy=0; req_ready=0 until any valid.
//  States: IDLE, LAUNCH, WAIT_DONE, GAP.
//  IDLE:
//   - Winner = first i with req_valid[i]=1, scanning from ptr+1 upward with wrap-around.
//   - req_ready[winner]=1 only while in IDLE; other bits are 0. Handshake completes in that same cycle.
//   - On handshake: latch req_data slice into tx_data and winner into grant_id; go to LAUNCH.
//   - No valid: stay in IDLE, outputs hold.
//  LAUNCH: tx_start=1 for exactly this cycle; clear watchdog; go to WAIT_DONE.
//  WAIT_DONE:
//   - Watchdog increments every cycle.
//   - tx_done=1: frame_done=1 next cycle; ptr<=grant_id; go to GAP, or to IDLE if GAP_CYCLES=0.
//   - Otherwise, watchdog reaching TIMEOUT_CYCLES-1: timeout_err=1 next cycle; ptr<=grant_id; same exit.
//   - tx_done and timeout in the same cycle: done wins; no timeout_err.
//  GAP: counts GAP_CYCLES cycles, then goes to IDLE. req_ready stays 0 throughout.
//  tx_done seen in any state other than WAIT_DONE is ignored; no pulse and no state change.
//  Latency:
//   - Handshake at cycle n -> tx_start at n+1.
//   - tx_done at cycle m -> frame_done at m+1; IDLE at m+1+GAP_CYCLES.
//   - Earliest next handshake is m+1+GAP_CYCLES.
//  A requester deasserting req_valid before its handshake simply loses the grant; nothing is latched.
//  Reset mid-frame returns to IDLE at once. tx_start drops; a serializer frame in flight is not tracked.
//  Fairness: with all requesters valid, grants rotate 0,1,2,...,N_REQ-1,0; no requester waits more than N_REQ frames.
// TESTING
//  T1 Single request: req_valid=4'b0100, byte 0xA5 -> req_ready=4'b0100 for 1 cycle; tx_start next cycle; tx_data=0xA5, grant_id=2.
//     Then tx_done -> frame_done 1 cycle later.
//  T2 Round-robin: all four valid continuously, serializer model returns done 11 cycles after start.
//     -> grant order 0,1,2,3,0,1. Next handshake exactly GAP_CYCLES+1 cycles after each done.
//  T3 Timeout: tx_done tied 0 -> timeout_err pulses once, TIMEOUT_CYCLES cycles after tx_start.
//     frame_done stays 0; next requester is granted.
//  T4 Done/timeout collision: tx_done in the watchdog-expiry cycle -> frame_done=1, timeout_err=0.
//  T5 Reset mid-frame: Rst_n low during WAIT_DONE -> all outputs reset immediately.
//     After release, requester 0 wins over 3 when both are valid.
//  T6 Spurious done and GAP=0: tx_done pulse in IDLE -> no frame_done.
//     With GAP_CYCLES=0, back-to-back frames: handshake in the cycle after done.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART TX serializer between N_REQ byte sources.
// Grants one requester per frame, launches the serializer, waits for its done pulse under a
// watchdog, then holds off new grants for GAP_CYCLES idle cycles.
module uart_tx_scheduler #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned N_REQ          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned GAP_CYCLES     = 2
) (
   input  logic                          clk,
   input  logic                          Rst_n,
   input  logic [N_REQ-1:0]              req_valid,
   output logic [N_REQ-1:0]              req_ready,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
   output logic                          tx_start,
   output logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_done,
   output logic [$clog2(N_REQ)-1:0]      grant_id,
   output logic                          busy,
   output logic                          frame_done,
   output logic                          timeout_err
);

   localparam int unsigned IdW  = $clog2(N_REQ);
   localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CYCLES - 1);
   localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {StIdle, StLaunch, StWaitDone, StGap} state_e;

   state_e                state_q, state_d;
   logic [IdW-1:0]        ptr_q, ptr_d;
   logic [IdW-1:0]        grant_q, grant_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [WdW-1:0]        wdog_q, wdog_d;
   logic [WdW-1:0]        wdog_inc;
   logic [GapW-1:0]       gap_q, gap_d;
   logic                  frame_done_q, frame_done_d;
   logic                  timeout_err_q, timeout_err_d;

   logic [IdW-1:0]        winner;
   logic [IdW-1:0]        scan_idx;
   logic                  any_valid;
   logic [DATA_WIDTH-1:0] req_bytes [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
      assign req_bytes[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // Round-robin pick: first valid requester after the last one served, with wrap-around.
   always_comb begin
      winner    = '0;
      scan_idx  = '0;
      any_valid = 1'b0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         scan_idx = IdW'((32'(ptr_q) + k) % N_REQ);
         if (!any_valid && req_valid[scan_idx]) begin
            any_valid = 1'b1;
            winner    = scan_idx;
         end
      end
   end

   // Next-state, handshake and pulse generation.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_d       = grant_q;
      data_d        = data_q;
      wdog_d        = wdog_q;
      gap_d         = gap_q;
      frame_done_d  = 1'b0;
      timeout_err_d = 1'b0;
      req_ready     = '0;
      wdog_inc      = wdog_q + 1'b1;
      unique case (state_q)
         StIdle: begin
            if (any_valid) begin
               req_ready[winner] = 1'b1;
               data_d            = req_bytes[winner];
               grant_d           = winner;
               state_d           = StLaunch;
            end
         end
         StLaunch: begin
            wdog_d  = '0;
            state_d = StWaitDone;
         end
         StWaitDone: begin
            wdog_d = wdog_inc;
            // A done arriving in the expiry cycle still counts as a good frame.
            if (tx_done || (wdog_inc == WdLast)) begin
               frame_done_d  = tx_done;
               timeout_err_d = !tx_done;
               ptr_d         = grant_q;
               gap_d         = '0;
               state_d       = (GAP_CYCLES == 0) ? StIdle : StGap;
            end
         end
         StGap: begin
            if (gap_q == GapLast) begin
               state_d = StIdle;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; ptr resets to the last index so requester 0 goes first.
   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q       <= StIdle;
         ptr_q         <= IdW'(N_REQ - 1);
         grant_q       <= '0;
         data_q        <= '0;
         wdog_q        <= '0;
         gap_q         <= '0;
         frame_done_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_q       <= grant_d;
         data_q        <= data_d;
         wdog_q        <= wdog_d;
         gap_q         <= gap_d;
         frame_done_q  <= frame_done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign tx_start    = (state_q == StLaunch);
   assign busy        = (state_q != StIdle);
   assign tx_data     = data_q;
   assign grant_id    = grant_q;
   assign frame_done  = frame_done_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: one instance with a 2-cycle gap, one with no gap.
// Inputs change just after the falling edge; outputs are sampled mid-cycle.
module tb_uart_tx_scheduler;

   localparam int unsigned DW  = 8;
   localparam int unsigned NR  = 4;
   localparam int unsigned TO  = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Instance with GAP_CYCLES=2
   logic [NR-1:0]    req_valid, req_ready;
   logic [NR*DW-1:0] req_data;
   logic             tx_start, tx_done, busy, frame_done, timeout_err;
   logic [DW-1:0]    tx_data;
   logic [1:0]       grant_id;

   // Instance with GAP_CYCLES=0
   logic [NR-1:0]    req_valid0, req_ready0;
   logic [NR*DW-1:0] req_data0;
   logic             tx_start0, tx_done0, busy0, frame_done0, timeout_err0;
   logic [DW-1:0]    tx_data0;
   logic [1:0]       grant_id0;

   uart_tx_scheduler #(
      .DATA_WIDTH(DW), .N_REQ(NR), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(2)
   ) u_dut (
      .clk(clk), .Rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
      .grant_id(grant_id), .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
   );

   uart_tx_scheduler #(
      .DATA_WIDTH(DW), .N_REQ(NR), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(0)
   ) u_dut0 (
      .clk(clk), .Rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_data(req_data0), .tx_start(tx_start0), .tx_data(tx_data0), .tx_done(tx_done0),
      .grant_id(grant_id0), .busy(busy0), .frame_done(frame_done0), .timeout_err(timeout_err0)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL sim_watchdog: got timeout expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      req_valid  = '0; req_data  = '0; tx_done  = 1'b0;
      req_valid0 = '0; req_data0 = '0; tx_done0 = 1'b0;
      rst_n = 1'b0;
      repeat (2) tick();
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_timeout_err", timeout_err, 0);
      check("rst_req_ready", req_ready, 0);
      rst_n = 1'b1;

      // T1: single request from requester 2
      req_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
      req_valid = 4'b0100;
      #1;
      check("t1_ready", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      #1;
      check("t1_start", tx_start, 1);
      check("t1_data", tx_data, 8'hA5);
      check("t1_gid", grant_id, 2);
      check("t1_ready_low", req_ready, 0);
      check("t1_busy", busy, 1);
      tick();
      check("t1_start_once", tx_start, 0);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("t1_frame_done", frame_done, 1);
      check("t1_busy_gap", busy, 1);
      tick();
      check("t1_frame_done_pulse", frame_done, 0);
      tick();
      check("t1_idle", busy, 0);

      // T2: all valid, done 11 cycles after each start, grants rotate
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
      req_valid = 4'hF;
      for (int f = 0; f < 6; f++) begin
         #1;
         check("t2_ready", req_ready, 32'(1) << (f % 4));
         tick();
         check("t2_start", tx_start, 1);
         check("t2_gid", grant_id, 32'(f % 4));
         check("t2_data", tx_data, 32'h10 + 32'(f % 4));
         repeat (10) tick();
         tick();
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
         check("t2_frame_done", frame_done, 1);
         tick();
         #1;
         check("t2_gap_ready", req_ready, 0);
         tick();
      end

      // T3: watchdog timeout on requester 2, then requester 3 is granted
      #1;
      check("t3_ready", req_ready, 4'b0100);
      tick();
      check("t3_start", tx_start, 1);
      check("t3_gid", grant_id, 2);
      repeat (14) tick();
      check("t3_no_to_early14", timeout_err, 0);
      tick();
      check("t3_no_to_early15", timeout_err, 0);
      tick();
      check("t3_timeout", timeout_err, 1);
      check("t3_no_frame_done", frame_done, 0);
      tick();
      check("t3_timeout_pulse", timeout_err, 0);
      check("t3_gap_ready", req_ready, 0);
      tick();
      #1;
      check("t3_next_ready", req_ready, 4'b1000);

      // T4: done lands in the watchdog-expiry cycle
      tick();
      check("t4_start", tx_start, 1);
      check("t4_gid", grant_id, 3);
      repeat (14) tick();
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("t4_frame_done", frame_done, 1);
      check("t4_no_timeout", timeout_err, 0);
      tick();
      check("t4_no_timeout_late", timeout_err, 0);
      tick();
      #1;
      check("t4_next_ready", req_ready, 4'b0001);

      // T5: serve requester 0, then reset during requester 1's frame
      tick();
      check("t5_gid0", grant_id, 0);
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("t5_frame_done", frame_done, 1);
      tick();
      tick();
      #1;
      check("t5_ready1", req_ready, 4'b0010);
      tick();
      check("t5_gid1", grant_id, 1);
      check("t5_start1", tx_start, 1);
      tick();
      tick();
      check("t5_busy_wait", busy, 1);
      rst_n = 1'b0;
      req_valid = 4'b1001;
      #1;
      check("t5_rst_start", tx_start, 0);
      check("t5_rst_data", tx_data, 0);
      check("t5_rst_gid", grant_id, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_frame_done", frame_done, 0);
      check("t5_rst_timeout", timeout_err, 0);
      tick();
      rst_n = 1'b1;
      #1;
      check("t5_ready_after_rst", req_ready, 4'b0001);
      tick();
      check("t5_gid_after_rst", grant_id, 0);
      check("t5_data_after_rst", tx_data, 8'h10);
      req_valid = '0;

      // T6: spurious done in IDLE, then back-to-back frames with no gap
      tx_done0 = 1'b1;
      tick();
      tx_done0 = 1'b0;
      check("t6_spurious_fd", frame_done0, 0);
      check("t6_spurious_busy", busy0, 0);
      tick();
      check("t6_spurious_fd_late", frame_done0, 0);
      req_data0  = {8'h77, 8'h66, 8'h5A, 8'h3C};
      req_valid0 = 4'b0001;
      #1;
      check("t6_ready0", req_ready0, 4'b0001);
      tick();
      check("t6_start0", tx_start0, 1);
      check("t6_data0", tx_data0, 8'h3C);
      req_valid0 = 4'b0010;
      tick();
      tx_done0 = 1'b1;
      tick();
      tx_done0 = 1'b0;
      #1;
      check("t6_frame_done", frame_done0, 1);
      check("t6_idle", busy0, 0);
      check("t6_ready1", req_ready0, 4'b0010);
      tick();
      check("t6_start1", tx_start0, 1);
      check("t6_data1", tx_data0, 8'h5A);
      check("t6_gid1", grant_id0, 1);
      req_valid0 = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
